dac_pulse_seq: RTL and testbench
================================

Name: dac_pulse_seq

Overview:
- Sequencer that generates the `dac_top_state` and `pulse18_state`/`pulse28_state` codes consumed by the analog switch drivers (the `in16`-class drivers) and the DAC path.
- Runs one programming sequence during the training phase (`system_state==2`, `key_state` high):
  - stage 1 uses the 18-pulse;
  - stage 2 uses the 28-pulse;
  - then a read window.
- Sits beside the top-level system FSM. It drives the switch decoders; it receives nothing back from them.

Parameters:
- `T_RISE`, 4: cycles `pulseXX_state`=1 in a V1 state (legal 1..65535).
- `T_HOLD`, 16: cycles `pulseXX_state`=2 in a V1 state (legal 1..65535).
- `T_FALL`, 4: cycles `pulseXX_state`=3 in a V1 state (legal 1..65535).
- `T_V2`, 32: cycles spent in each V2 state (legal 1..65535).
- `T_GAP`, 8: cycles spent in each CNT state (legal 1..65535).
- `T_READ`, 64: cycles spent in `V_READ` (legal 1..65535).
- `N_REPEAT`, 2: stage-1+2 iterations; used only with `PULSE_REPEAT_EN` (legal 1..255).

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `system_state`  in  3  top FSM state; 2 = training
- `key_state`  in  1  enable; low forces idle
- `start`  in  1  one-cycle start request
- `dac_top_state`  out  4  sequencer state code
- `pulse18_state`  out  2  stage-1 pulse phase: 0 off, 1 rise, 2 hold, 3 fall
- `pulse28_state`  out  2  stage-2 pulse phase, same coding
- `busy`  out  1  high whenever `dac_top_state`≠IDLE
- `done`  out  1  one-cycle pulse while in COMPLETE

Behaviour:
- Reset and clocking:
  - One clock; reset is asynchronous and active-low (`clk`, `rst_n`).
  - All outputs are registered.
  - Reset values: `dac_top_state`=IDLE, `pulse18_state`=0, `pulse28_state`=0, `busy`=0, `done`=0; counters and iteration count = 0.
- State encoding (fixed, shared with the decoders): IDLE=0, V1_2=1, CNT_1_2=2, V2_2=3, CNT_2_2=4, V_READ=5, COMPLETE=6, V1_1=7, V2_1=8, CNT_1_1=9, CNT_2_1=10. Codes 11..15 are never driven.
- Arm condition `arm` = `key_state` && `system_state`==2.
- Abort:
  - Any cycle with `arm` low forces next state IDLE and both pulse codes to 0, regardless of current state.
  - Abort has priority over every transition and over `start`.
- IDLE exits to V1_1 on `arm` && `start`. `start` is ignored when not in IDLE (no queuing).
- Stage 1:
  - V1_1: `pulse18_state` = 1 for `T_RISE` cycles, then 2 for `T_HOLD`, then 3 for `T_FALL`. The phase code changes on the same edge that enters V1_1.
  - After the last fall cycle: next state CNT_1_1 and `pulse18_state`=0.
  - CNT_1_1 lasts `T_GAP` cycles, then V2_1.
  - V2_1 lasts `T_V2` cycles, then CNT_2_1.
  - CNT_2_1 lasts `T_GAP` cycles, then V1_2.
- Stage 2 runs identically through V1_2 → CNT_1_2 → V2_2 → CNT_2_2, using `pulse28_state`.
- CNT_2_2 → V_READ (`T_READ` cycles) → COMPLETE.
- COMPLETE lasts exactly 1 cycle with `done`=1, then IDLE.
- Pulse exclusivity: outside V1_1 `pulse18_state`=0; outside V1_2 `pulse28_state`=0. Both codes are never nonzero in the same cycle.
- Dwell counter:
  - One shared 16-bit down-counter, loaded with (duration−1) on each state/phase entry.
  - Advance when the counter reads 0. Every state/phase dwell is exactly its parameter in cycles.
- Total sequence latency from the `start` sample to `done`=1 is 2·(`T_RISE`+`T_HOLD`+`T_FALL`+2·`T_GAP`+`T_V2`)+`T_READ` cycles. Defaults give 2·(24+16+32)+64 = 208.
- Reset mid-sequence returns all outputs to reset values immediately (asynchronous).

Optional Feature:
- Macro: `PULSE_REPEAT_EN`.
- Defined:
  - CNT_2_2 returns to V1_1 until `N_REPEAT` iterations are complete, then goes to V_READ.
  - An 8-bit iteration counter clears in IDLE and increments on each CNT_2_2 exit.
  - Abort clears it.
- Undefined: single iteration; `N_REPEAT` is ignored and no iteration counter is built.

Test Plan:
- Reset with `rst_n`=0, then release; hold `start`=0 → `dac_top_state`=0, both pulse codes 0, `busy`=0 for 20 cycles.
- Defaults, `system_state`=2, `key_state`=1, 1-cycle `start`:
  - `pulse18_state` sequence is 1×4, 2×16, 3×4.
  - `dac_top_state` visits 7,9,8,10,1,2,3,4,5,6,0.
  - `done` is high 208 cycles after `start` is sampled, for 1 cycle.
- Drop `key_state` to 0 during V2_1 (cycle 50) → next cycle `dac_top_state`=0, pulses 0; a re-`start` restarts at V1_1.
- `start` asserted while `system_state`=3, and `start` pulsed mid-sequence → no effect; sequence timing unchanged.
- Assert `rst_n`=0 during the V1_2 hold phase → outputs 0 asynchronously, before the next edge.
- With `PULSE_REPEAT_EN` defined, `N_REPEAT`=2 → V1_1 is entered twice and `done` arrives at 2·144+64 = 352 cycles.

Source files
------------

// File: rtl/dac_pulse_seq_if.sv
// Control/status bundle between the system FSM side and the DAC pulse sequencer.
// The master drives the training context and the start request, and the sequencer
// (slave) returns the state and pulse codes that feed the switch decoders.
interface dac_pulse_seq_if;
    logic [2:0] system_state;
    logic       key_state;
    logic       start;
    logic [3:0] dac_top_state;
    logic [1:0] pulse18_state;
    logic [1:0] pulse28_state;
    logic       busy;
    logic       done;

    modport master (
        output system_state, key_state, start,
        input  dac_top_state, pulse18_state, pulse28_state, busy, done
    );

    modport slave (
        input  system_state, key_state, start,
        output dac_top_state, pulse18_state, pulse28_state, busy, done
    );
endinterface

// File: rtl/dac_pulse_seq.sv
// DAC programming-pulse sequencer: stage 1 (18-pulse), stage 2 (28-pulse), read window.
// Every state and pulse phase dwells on one shared 16-bit down-counter that is loaded
// with (duration-1) on entry. The sequence advances on the cycle the counter reads 0.
// Optional build macro PULSE_REPEAT_EN: repeats stage 1+2 N_REPEAT times before the read.
module dac_pulse_seq #(
    parameter int unsigned T_RISE   = 4,
    parameter int unsigned T_HOLD   = 16,
    parameter int unsigned T_FALL   = 4,
    parameter int unsigned T_V2     = 32,
    parameter int unsigned T_GAP    = 8,
    parameter int unsigned T_READ   = 64,
    parameter int unsigned N_REPEAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dac_pulse_seq_if.slave        bus
);

    // State codes are shared with the switch decoders and must not be renumbered.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        V1_2     = 4'd1,
        CNT_1_2  = 4'd2,
        V2_2     = 4'd3,
        CNT_2_2  = 4'd4,
        V_READ   = 4'd5,
        COMPLETE = 4'd6,
        V1_1     = 4'd7,
        V2_1     = 4'd8,
        CNT_1_1  = 4'd9,
        CNT_2_1  = 4'd10
    } state_e;

    localparam logic [15:0] RISE_LOAD = 16'(T_RISE - 1);
    localparam logic [15:0] HOLD_LOAD = 16'(T_HOLD - 1);
    localparam logic [15:0] FALL_LOAD = 16'(T_FALL - 1);
    localparam logic [15:0] V2_LOAD   = 16'(T_V2 - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(T_GAP - 1);
    localparam logic [15:0] READ_LOAD = 16'(T_READ - 1);

    // Reject out-of-range dwell settings at elaboration time.
    if (T_RISE < 1 || T_RISE > 65535 || T_HOLD < 1 || T_HOLD > 65535 ||
        T_FALL < 1 || T_FALL > 65535 || T_V2 < 1 || T_V2 > 65535 ||
        T_GAP < 1 || T_GAP > 65535 || T_READ < 1 || T_READ > 65535 ||
        N_REPEAT < 1 || N_REPEAT > 255) begin : g_bad_params
        $error("dac_pulse_seq: parameter out of legal range");
    end

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  p18_q, p18_d;
    logic [1:0]  p28_q, p28_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  phase_d;
    logic        arm;
`ifdef PULSE_REPEAT_EN
    logic [7:0]  iter_q, iter_d;
`endif

    assign arm = bus.key_state && (bus.system_state == 3'd2);

    // Next-state, dwell counter and pulse-phase decode; abort has top priority.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p18_d   = p18_q;
        p28_d   = p28_q;
        phase_d = 2'd0;
`ifdef PULSE_REPEAT_EN
        iter_d  = iter_q;
`endif
        if (!arm) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
            p18_d   = 2'd0;
            p28_d   = 2'd0;
`ifdef PULSE_REPEAT_EN
            iter_d  = 8'd0;
`endif
        end else if (state_q != IDLE && cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = 16'd0;
`ifdef PULSE_REPEAT_EN
                    iter_d = 8'd0;
`endif
                    if (bus.start) begin
                        state_d = V1_1;
                        p18_d   = 2'd1;
                        cnt_d   = RISE_LOAD;
                    end
                end
                V1_1, V1_2: begin
                    case ((state_q == V1_1) ? p18_q : p28_q)
                        2'd1: begin
                            phase_d = 2'd2;
                            cnt_d   = HOLD_LOAD;
                        end
                        2'd2: begin
                            phase_d = 2'd3;
                            cnt_d   = FALL_LOAD;
                        end
                        default: begin
                            phase_d = 2'd0;
                            cnt_d   = GAP_LOAD;
                            state_d = (state_q == V1_1) ? CNT_1_1 : CNT_1_2;
                        end
                    endcase
                    if (state_q == V1_1) p18_d = phase_d;
                    else                 p28_d = phase_d;
                end
                CNT_1_1: begin
                    state_d = V2_1;
                    cnt_d   = V2_LOAD;
                end
                V2_1: begin
                    state_d = CNT_2_1;
                    cnt_d   = GAP_LOAD;
                end
                CNT_2_1: begin
                    state_d = V1_2;
                    p28_d   = 2'd1;
                    cnt_d   = RISE_LOAD;
                end
                CNT_1_2: begin
                    state_d = V2_2;
                    cnt_d   = V2_LOAD;
                end
                V2_2: begin
                    state_d = CNT_2_2;
                    cnt_d   = GAP_LOAD;
                end
                CNT_2_2: begin
`ifdef PULSE_REPEAT_EN
                    iter_d = iter_q + 8'd1;
                    if (({1'b0, iter_q} + 9'd1) < 9'(N_REPEAT)) begin
                        state_d = V1_1;
                        p18_d   = 2'd1;
                        cnt_d   = RISE_LOAD;
                    end else begin
                        state_d = V_READ;
                        cnt_d   = READ_LOAD;
                    end
`else
                    state_d = V_READ;
                    cnt_d   = READ_LOAD;
`endif
                end
                V_READ: begin
                    state_d = COMPLETE;
                    cnt_d   = 16'd0;
                end
                COMPLETE: begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                    p18_d   = 2'd0;
                    p28_d   = 2'd0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == COMPLETE);
    end

    // State, counter and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            p18_q   <= 2'd0;
            p28_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p18_q   <= p18_d;
            p28_q   <= p28_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef PULSE_REPEAT_EN
    // Iteration count of completed stage 1+2 passes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) iter_q <= 8'd0;
        else        iter_q <= iter_d;
    end
`endif

    assign bus.dac_top_state = state_q;
    assign bus.pulse18_state = p18_q;
    assign bus.pulse28_state = p28_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_dac_pulse_seq.sv
// Directed bench for dac_pulse_seq with default timing parameters.
// Expected waveforms come from the hand-derived cycle timeline of the sequence
// (24 V1 cycles, 8 gap, 32 V2, 8 gap per stage; 64 read cycles; 1 complete cycle).
module tb_dac_pulse_seq;

    localparam int STAGE_LEN = 144;
`ifdef PULSE_REPEAT_EN
    localparam int ITERS = 2;
`else
    localparam int ITERS = 1;
`endif
    localparam int READ_START = ITERS * STAGE_LEN;
    localparam int DONE_N     = READ_START + 64;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    dac_pulse_seq_if bus();

    dac_pulse_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 100 MHz-style clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle n counts edges after the edge that sampled start (n=0 is first V1_1 cycle).
    function automatic logic [15:0] expState(input int n);
        int m;
        if (n < READ_START) begin
            m = n % STAGE_LEN;
            if (m < 24)       return 16'd7;
            else if (m < 32)  return 16'd9;
            else if (m < 64)  return 16'd8;
            else if (m < 72)  return 16'd10;
            else if (m < 96)  return 16'd1;
            else if (m < 104) return 16'd2;
            else if (m < 136) return 16'd3;
            else              return 16'd4;
        end
        if (n < DONE_N)  return 16'd5;
        if (n == DONE_N) return 16'd6;
        return 16'd0;
    endfunction

    function automatic logic [15:0] expPhase(input int off);
        if (off < 4)  return 16'd1;
        if (off < 20) return 16'd2;
        return 16'd3;
    endfunction

    function automatic logic [15:0] expP18(input int n);
        if (n < READ_START && (n % STAGE_LEN) < 24) return expPhase(n % STAGE_LEN);
        return 16'd0;
    endfunction

    function automatic logic [15:0] expP28(input int n);
        int m;
        m = n % STAGE_LEN;
        if (n < READ_START && m >= 72 && m < 96) return expPhase(m - 72);
        return 16'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int n,
                               input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int n, input logic [15:0] st,
                            input logic [15:0] p18, input logic [15:0] p28,
                            input logic [15:0] bsy, input logic [15:0] dn);
        checkOutput({tag, ".state"}, n, 16'(bus.dac_top_state), st);
        checkOutput({tag, ".p18"},   n, 16'(bus.pulse18_state), p18);
        checkOutput({tag, ".p28"},   n, 16'(bus.pulse28_state), p28);
        checkOutput({tag, ".busy"},  n, 16'(bus.busy), bsy);
        checkOutput({tag, ".done"},  n, 16'(bus.done), dn);
    endtask

    // Pulse start once, then follow the whole sequence cycle by cycle.
    // A non-negative pulseAt re-asserts start mid-sequence, which must be ignored.
    task automatic applyStimulus(input string tag, input int pulseAt);
        logic [15:0] st;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n <= DONE_N + 1; n++) begin
            st = expState(n);
            checkAll(tag, n, st, expP18(n), expP28(n),
                     (st != 16'd0) ? 16'd1 : 16'd0, (st == 16'd6) ? 16'd1 : 16'd0);
            bus.start = (n == pulseAt);
            tick();
        end
        bus.start = 1'b0;
    endtask

    // Start a sequence and stop after a given number of cycles into it.
    task automatic startAndAdvance(input int cycles);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (cycles) tick();
    endtask

    // Directed scenario list.
    initial begin
        rst_n            = 1'b0;
        bus.system_state = 3'd2;
        bus.key_state    = 1'b1;
        bus.start        = 1'b0;

        repeat (2) tick();
        checkAll("reset", 0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            checkAll("idle", i, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        end

        applyStimulus("main", -1);

        startAndAdvance(50);
        checkOutput("abort.pre", 50, 16'(bus.dac_top_state), 16'd8);
        bus.key_state = 1'b0;
        tick();
        checkAll("abort", 51, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        bus.key_state = 1'b1;
        tick();
        checkOutput("abort.idle", 52, 16'(bus.dac_top_state), 16'd0);

        applyStimulus("restart", 30);

        bus.system_state = 3'd3;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
        checkAll("sys3", 0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        bus.system_state = 3'd2;
        tick();
        checkOutput("sys3.noqueue", 1, 16'(bus.dac_top_state), 16'd0);

        applyStimulus("midstart", 150);

        startAndAdvance(80);
        checkOutput("rst.pre.state", 80, 16'(bus.dac_top_state), 16'd1);
        checkOutput("rst.pre.p28",   80, 16'(bus.pulse28_state), 16'd2);
        #2 rst_n = 1'b0;
        #1;
        checkAll("asyncrst", 80, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        #2 rst_n = 1'b1;
        tick();
        checkAll("postrst", 81, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
